// File: rtl/gf180mcu_fd_sc_mcu9t5v0__inv_bank_seq.sv
// Staggered enable sequencer for a bank of parallel inverter segments.
// Segments are switched one at a time, STEP_DIV clocks apart, to limit supply inrush.
//
// state  | meaning
// -------+-----------------------------------------------
// S_OFF  | all segments off, waiting for EN
// S_UP   | ramping on, one more segment every STEP_DIV clocks
// S_ON   | all segments on, READY asserted
// S_DOWN | ramping off, one fewer segment every STEP_DIV clocks
module gf180mcu_fd_sc_mcu9t5v0__inv_bank_seq #(
  parameter int N_SEG    = 16,
  parameter int STEP_DIV = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             KILL,
  output logic [N_SEG-1:0] SEG_EN,
  output logic             READY,
  output logic             BUSY,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int CW = $clog2(N_SEG + 1);
  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_FULL   = CW'(N_SEG);
  localparam logic [CW-1:0] CNT_PENULT = CW'(N_SEG - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [TW-1:0] TMR_LAST   = TW'(STEP_DIV - 1);

  typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [TW-1:0]    tmr, tmr_nxt;
  logic [N_SEG-1:0] seg_nxt;

  // Supply pins carry no logic; tie them into a sink so they are not flagged.
  wire unused_supply;
  assign unused_supply = VDD ^ VSS;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tmr_nxt   = tmr;
    if (KILL) begin
      state_nxt = S_OFF;
      cnt_nxt   = '0;
      tmr_nxt   = '0;
    end else begin
      case (state)
        S_OFF: begin
          if (EN) begin
            state_nxt = S_UP;
            cnt_nxt   = CNT_ONE;
            tmr_nxt   = '0;
          end
        end
        S_UP: begin
          if (!EN) begin
            cnt_nxt   = cnt - CNT_ONE;
            tmr_nxt   = '0;
            state_nxt = (cnt == CNT_ONE) ? S_OFF : S_DOWN;
          end else if (tmr == TMR_LAST) begin
            cnt_nxt   = cnt + CNT_ONE;
            tmr_nxt   = '0;
            state_nxt = (cnt == CNT_PENULT) ? S_ON : S_UP;
          end else begin
            tmr_nxt = tmr + TW'(1);
          end
        end
        S_ON: begin
          if (!EN) begin
            state_nxt = S_DOWN;
            cnt_nxt   = CNT_PENULT;
            tmr_nxt   = '0;
          end
        end
        S_DOWN: begin
          if (EN) begin
            cnt_nxt   = cnt + CNT_ONE;
            tmr_nxt   = '0;
            state_nxt = (cnt == CNT_PENULT) ? S_ON : S_UP;
          end else if (tmr == TMR_LAST) begin
            cnt_nxt   = cnt - CNT_ONE;
            tmr_nxt   = '0;
            state_nxt = (cnt == CNT_ONE) ? S_OFF : S_DOWN;
          end else begin
            tmr_nxt = tmr + TW'(1);
          end
        end
        default: begin
          state_nxt = S_OFF;
          cnt_nxt   = '0;
          tmr_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next count and registered, so no input reaches a pin combinationally.
  always_comb begin
    seg_nxt = '0;
    for (int i = 0; i < N_SEG; i++) begin
      seg_nxt[i] = (cnt_nxt > CW'(i));
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state  <= S_OFF;
      cnt    <= '0;
      tmr    <= '0;
      SEG_EN <= '0;
      READY  <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      tmr    <= tmr_nxt;
      SEG_EN <= seg_nxt;
      READY  <= (state_nxt == S_ON);
      BUSY   <= (state_nxt == S_UP) || (state_nxt == S_DOWN);
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__inv_bank_seq.sv
// Bench for the inverter-bank sequencer: a 16x4 instance and a 2x1 instance,
// checked against a level/age model of the staggered ramp.
module tb_gf180mcu_fd_sc_mcu9t5v0__inv_bank_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn, en_a, kill_a, en_b, kill_b;
  logic [15:0] seg_a;
  logic        rdy_a, busy_a;
  logic [1:0]  seg_b;
  logic        rdy_b, busy_b;
  wire         vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int lvl_a, age_a, dir_a, lvl_b, age_b, dir_b;

  gf180mcu_fd_sc_mcu9t5v0__inv_bank_seq #(.N_SEG(16), .STEP_DIV(4)) dut_a (
    .CLK(clk), .RN(rn), .EN(en_a), .KILL(kill_a),
    .SEG_EN(seg_a), .READY(rdy_a), .BUSY(busy_a), .VDD(vdd), .VSS(vss));

  gf180mcu_fd_sc_mcu9t5v0__inv_bank_seq #(.N_SEG(2), .STEP_DIV(1)) dut_b (
    .CLK(clk), .RN(rn), .EN(en_b), .KILL(kill_b),
    .SEG_EN(seg_b), .READY(rdy_b), .BUSY(busy_b), .VDD(vdd), .VSS(vss));

  // Level moves toward the EN target; a start or reversal moves at once, otherwise
  // a move happens STEP_DIV clocks after the previous one.
  task automatic model_step(input int n, input int sd, input logic en, input logic kill,
                            inout int lvl, inout int age, inout int dir);
    int tgt;
    int d;
    if (kill) begin
      lvl = 0; age = 0; dir = 0;
    end else begin
      tgt = en ? n : 0;
      if (lvl == tgt) begin
        dir = 0; age = 0;
      end else begin
        d = (tgt > lvl) ? 1 : -1;
        if (d != dir || age == sd - 1) begin
          lvl = lvl + d;
          age = 0;
          dir = (lvl == 0 || lvl == n) ? 0 : d;
        end else begin
          age = age + 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] therm(input int lvl);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < lvl; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [17:0] exp_a_f();
    logic [31:0] t;
    t = therm(lvl_a);
    return {t[15:0], lvl_a == 16, (lvl_a > 0 && lvl_a < 16)};
  endfunction

  function automatic logic [3:0] exp_b_f();
    logic [31:0] t;
    t = therm(lvl_b);
    return {t[1:0], lvl_b == 2, (lvl_b > 0 && lvl_b < 2)};
  endfunction

  task automatic tick();
    if (!rn) begin
      lvl_a = 0; age_a = 0; dir_a = 0;
      lvl_b = 0; age_b = 0; dir_b = 0;
    end else begin
      model_step(16, 4, en_a, kill_a, lvl_a, age_a, dir_a);
      model_step(2, 1, en_b, kill_b, lvl_b, age_b, dir_b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rn = 1'b1; en_a = 1'b0; kill_a = 1'b0; en_b = 1'b0; kill_b = 1'b0;
    #1 rn = 1'b0;
    #1;
    n_cmp++;
    if ({seg_a, rdy_a, busy_a} !== 18'h0) begin
      n_bad++; $display("FAIL reset_a: got %h want %h", {seg_a, rdy_a, busy_a}, 18'h0);
    end
    n_cmp++;
    if ({seg_b, rdy_b, busy_b} !== 4'h0) begin
      n_bad++; $display("FAIL reset_b: got %h want %h", {seg_b, rdy_b, busy_b}, 4'h0);
    end
    en_a = 1'b1; en_b = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({seg_a, seg_b} !== 18'h0) begin
      n_bad++; $display("FAIL reset_hold: got %h want %h", {seg_a, seg_b}, 18'h0);
    end
    en_a = 1'b0; en_b = 1'b0;
    @(negedge clk);
    rn = 1'b1;
    tick();
  endtask

  task automatic check_a(input string nm, input int e);
    logic [17:0] ea;
    ea = exp_a_f();
    n_cmp++;
    if ({seg_a, rdy_a, busy_a} !== ea) begin
      n_bad++; $display("FAIL %s_a e=%0d: got %h want %h", nm, e, {seg_a, rdy_a, busy_a}, ea);
    end
  endtask

  task automatic test_ramp_up();
    en_a = 1'b1;
    for (int e = 0; e <= 60; e++) begin
      tick();
      check_a("ramp_up", e);
      if (e == 0) begin
        n_cmp++;
        if (seg_a !== 16'h0001) begin n_bad++; $display("FAIL up_e0: got %h want 0001", seg_a); end
      end
      if (e == 4) begin
        n_cmp++;
        if (seg_a !== 16'h0003) begin n_bad++; $display("FAIL up_e4: got %h want 0003", seg_a); end
      end
      if (e < 60) begin
        n_cmp++;
        if (busy_a !== 1'b1 || rdy_a !== 1'b0) begin
          n_bad++; $display("FAIL up_busy e=%0d: got busy=%b ready=%b want 1 0", e, busy_a, rdy_a);
        end
      end
    end
    n_cmp++;
    if ({seg_a, rdy_a, busy_a} !== {16'hFFFF, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL up_e60: got %h want %h", {seg_a, rdy_a, busy_a}, {16'hFFFF, 2'b10});
    end
    for (int e = 0; e < 5; e++) begin
      tick();
      n_cmp++;
      if ({seg_a, rdy_a, busy_a} !== {16'hFFFF, 2'b10}) begin
        n_bad++; $display("FAIL on_hold e=%0d: got %h", e, {seg_a, rdy_a, busy_a});
      end
    end
  endtask

  task automatic test_ramp_down();
    en_a = 1'b0;
    for (int e = 0; e <= 60; e++) begin
      tick();
      check_a("ramp_dn", e);
      if (e == 0) begin
        n_cmp++;
        if ({seg_a, busy_a} !== {16'h7FFF, 1'b1}) begin
          n_bad++; $display("FAIL dn_e0: got %h want 7fff busy", {seg_a, busy_a});
        end
      end
    end
    n_cmp++;
    if ({seg_a, rdy_a, busy_a} !== 18'h0) begin
      n_bad++; $display("FAIL dn_e60: got %h want 0", {seg_a, rdy_a, busy_a});
    end
  endtask

  task automatic test_reversal();
    logic [31:0] t;
    en_a = 1'b1;
    for (int e = 0; e <= 28; e++) tick();
    n_cmp++;
    if (seg_a !== 16'h00FF) begin n_bad++; $display("FAIL rev_top: got %h want 00ff", seg_a); end
    en_a = 1'b0;
    tick();
    n_cmp++;
    if ({seg_a, busy_a} !== {16'h007F, 1'b1}) begin
      n_bad++; $display("FAIL rev_first: got %h want 007f busy", {seg_a, busy_a});
    end
    for (int k = 1; k <= 28; k++) begin
      tick();
      check_a("rev", k);
      t = therm(7 - k / 4);
      n_cmp++;
      if (seg_a !== t[15:0]) begin
        n_bad++; $display("FAIL rev_step k=%0d: got %h want %h", k, seg_a, t[15:0]);
      end
    end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rev_end_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_kill();
    en_a = 1'b1;
    for (int e = 0; e <= 44; e++) tick();
    n_cmp++;
    if (seg_a !== 16'h0FFF) begin n_bad++; $display("FAIL kill_pre: got %h want 0fff", seg_a); end
    kill_a = 1'b1;
    tick();
    n_cmp++;
    if ({seg_a, rdy_a, busy_a} !== 18'h0) begin
      n_bad++; $display("FAIL kill_off: got %h want 0", {seg_a, rdy_a, busy_a});
    end
    kill_a = 1'b0;
    tick();
    n_cmp++;
    if ({seg_a, busy_a} !== {16'h0001, 1'b1}) begin
      n_bad++; $display("FAIL kill_restart: got %h want 0001 busy", {seg_a, busy_a});
    end
    en_a = 1'b0;
    tick();
    check_a("kill_end", 0);
  endtask

  task automatic test_async_reset();
    en_a = 1'b1;
    for (int e = 0; e <= 20; e++) tick();
    n_cmp++;
    if (seg_a !== 16'h003F) begin n_bad++; $display("FAIL arst_pre: got %h want 003f", seg_a); end
    #2 rn = 1'b0;
    #1;
    n_cmp++;
    if ({seg_a, rdy_a, busy_a} !== 18'h0) begin
      n_bad++; $display("FAIL arst_now: got %h want 0", {seg_a, rdy_a, busy_a});
    end
    lvl_a = 0; age_a = 0; dir_a = 0;
    lvl_b = 0; age_b = 0; dir_b = 0;
    en_a = 1'b0;
    @(negedge clk);
    rn = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      check_a("arst_idle", e);
    end
    en_a = 1'b1;
    tick();
    n_cmp++;
    if (seg_a !== 16'h0001) begin n_bad++; $display("FAIL arst_first: got %h want 0001", seg_a); end
    en_a = 1'b0;
    tick();
  endtask

  task automatic test_small();
    logic [3:0] eb;
    en_b = 1'b1;
    tick();
    n_cmp++;
    if ({seg_b, rdy_b, busy_b} !== 4'b0101) begin
      n_bad++; $display("FAIL small_e0: got %b want 0101", {seg_b, rdy_b, busy_b});
    end
    tick();
    n_cmp++;
    if ({seg_b, rdy_b, busy_b} !== 4'b1110) begin
      n_bad++; $display("FAIL small_e1: got %b want 1110", {seg_b, rdy_b, busy_b});
    end
    for (int e = 0; e < 20; e++) begin
      en_b = ~en_b;
      tick();
      eb = exp_b_f();
      n_cmp++;
      if ({seg_b, rdy_b, busy_b} !== eb || seg_b === 2'b10) begin
        n_bad++; $display("FAIL small_toggle e=%0d: got %b want %b", e, {seg_b, rdy_b, busy_b}, eb);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] eb;
    for (int e = 0; e < 3000; e++) begin
      if ($urandom_range(0, 19) == 0) en_a = ~en_a;
      kill_a = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 2) == 0) en_b = ~en_b;
      kill_b = ($urandom_range(0, 39) == 0);
      tick();
      check_a("rand", e);
      eb = exp_b_f();
      n_cmp++;
      if ({seg_b, rdy_b, busy_b} !== eb) begin
        n_bad++; $display("FAIL rand_b e=%0d: got %b want %b", e, {seg_b, rdy_b, busy_b}, eb);
      end
    end
  endtask

  initial begin
    lvl_a = 0; age_a = 0; dir_a = 0;
    lvl_b = 0; age_b = 0; dir_b = 0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_reversal();
    test_kill();
    test_async_reset();
    test_small();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
